// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, control encodings
// and the per-stage control word layouts.
package pipe_ctrl_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  typedef enum logic [1:0] {
    AluAdd    = 2'b00,
    AluBranch = 2'b01,
    AluR      = 2'b10,
    AluImm    = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbMem = 2'b01,
    WbPc4 = 2'b10
  } memtoreg_e;

  // Full control word as produced by decode and held in ID/EX.
  typedef struct packed {
    logic      alusrc;
    aluop_e    aluop;
    logic      branch;
    logic      jump;
    logic      memread;
    logic      memwrite;
    logic      regwrite;
    memtoreg_e memtoreg;
  } ctrl_t;

  // Later stages only carry the controls still ahead of them.
  typedef struct packed {
    logic      memread;
    logic      memwrite;
    logic      regwrite;
    memtoreg_e memtoreg;
  } mem_ctrl_t;

  typedef struct packed {
    logic      regwrite;
    memtoreg_e memtoreg;
  } wb_ctrl_t;

  localparam ctrl_t CtrlZero = '0;

  // Formats whose rs2 field is a real source operand.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OpcR) || (opcode == OpcStore) || (opcode == OpcBranch);
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder producing the full control word for the ID stage.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter bit          JUMP_EN    = 1'b1,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [6:0]            i_opcode,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output ctrl_t                 o_ctrl,
  output logic                  o_illegal
);

  // Table decode; unknown opcodes yield all-zero controls and flag illegal.
  always_comb begin
    o_ctrl    = CtrlZero;
    o_illegal = 1'b0;
    case (i_opcode)
      OpcR: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.aluop    = AluR;
      end
      OpcLoad: begin
        o_ctrl.memread  = 1'b1;
        o_ctrl.memtoreg = WbMem;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.aluop    = AluAdd;
      end
      OpcStore: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.aluop    = AluAdd;
      end
      OpcBranch: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.aluop  = AluBranch;
      end
      OpcImm: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.aluop    = AluImm;
      end
      OpcJal: begin
        if (JUMP_EN) begin
          o_ctrl.jump     = 1'b1;
          o_ctrl.regwrite = 1'b1;
          o_ctrl.memtoreg = WbPc4;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OpcJalr: begin
        if (JUMP_EN) begin
          o_ctrl.jump     = 1'b1;
          o_ctrl.alusrc   = 1'b1;
          o_ctrl.regwrite = 1'b1;
          o_ctrl.memtoreg = WbPc4;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
    // x0 is hardwired to zero, so never write it.
    if (i_rd == '0) o_ctrl.regwrite = 1'b0;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipeline control: carries decoded controls ID->EX->MEM->WB, detects load-use
// hazards, inserts bubbles on stall/flush and counts both events.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit          JUMP_EN    = 1'b1,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_id_opcode,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_illegal,
  output logic                  o_ex_alusrc,
  output logic                  o_ex_branch,
  output logic                  o_ex_jump,
  output logic [1:0]            o_ex_aluop,
  output logic [REG_ADDR_W-1:0] o_ex_rd,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_wb_regwrite,
  output logic [1:0]            o_wb_memtoreg,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  ctrl_t                 w_dec_ctrl;
  ctrl_t                 w_ex_ctrl_d;
  logic [REG_ADDR_W-1:0] w_ex_rd_d;
  logic                  w_stall;
  logic                  w_stall_cnt_inc;
  logic                  w_flush_cnt_inc;

  ctrl_t                 r_ex_ctrl;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  mem_ctrl_t             r_mem_ctrl;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  wb_ctrl_t              r_wb_ctrl;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  ctrl_decoder #(
    .JUMP_EN    (JUMP_EN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_ctrl_decoder (
    .i_opcode  (i_id_opcode),
    .i_rd      (i_id_rd),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (o_illegal)
  );

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    w_stall = 1'b0;
    if (r_ex_ctrl.memread && (r_ex_rd != '0)) begin
      w_stall = (r_ex_rd == i_id_rs1) ||
                ((r_ex_rd == i_id_rs2) && uses_rs2(i_id_opcode));
    end
  end

  // ID/EX next value: a bubble on flush or stall, else the decoded instruction.
  always_comb begin
    w_ex_ctrl_d = w_dec_ctrl;
    w_ex_rd_d   = i_id_rd;
    if (i_flush || w_stall) begin
      w_ex_ctrl_d = CtrlZero;
      w_ex_rd_d   = '0;
    end
  end

  // A stall overridden by flush is not counted; both counters stick at all-ones.
  always_comb begin
    w_stall_cnt_inc = w_stall && !i_flush && (r_stall_cnt != '1);
    w_flush_cnt_inc = i_flush && (r_flush_cnt != '1);
  end

  // Stage registers and event counters; reset discards everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_ctrl   <= CtrlZero;
      r_ex_rd     <= '0;
      r_mem_ctrl  <= '0;
      r_mem_rd    <= '0;
      r_wb_ctrl   <= '0;
      r_wb_rd     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_ex_ctrl           <= w_ex_ctrl_d;
      r_ex_rd             <= w_ex_rd_d;
      r_mem_ctrl.memread  <= r_ex_ctrl.memread;
      r_mem_ctrl.memwrite <= r_ex_ctrl.memwrite;
      r_mem_ctrl.regwrite <= r_ex_ctrl.regwrite;
      r_mem_ctrl.memtoreg <= r_ex_ctrl.memtoreg;
      r_mem_rd            <= r_ex_rd;
      r_wb_ctrl.regwrite  <= r_mem_ctrl.regwrite;
      r_wb_ctrl.memtoreg  <= r_mem_ctrl.memtoreg;
      r_wb_rd             <= r_mem_rd;
      if (w_stall_cnt_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_cnt_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall       = w_stall;
  assign o_ex_alusrc   = r_ex_ctrl.alusrc;
  assign o_ex_branch   = r_ex_ctrl.branch;
  assign o_ex_jump     = r_ex_ctrl.jump;
  assign o_ex_aluop    = r_ex_ctrl.aluop;
  assign o_ex_rd       = r_ex_rd;
  assign o_mem_read    = r_mem_ctrl.memread;
  assign o_mem_write   = r_mem_ctrl.memwrite;
  assign o_wb_regwrite = r_wb_ctrl.regwrite;
  assign o_wb_memtoreg = r_wb_ctrl.memtoreg;
  assign o_wb_rd       = r_wb_rd;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: three instances (default, JUMP_EN=0, CNT_W=2) share
// stimulus; a per-instance instruction-history model is compared every cycle, and
// directed scenarios pin the model with literal expectations.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic       fl;

  logic       st[3], il[3], alusrc[3], br[3], jp[3], mr[3], mw[3], rw[3];
  logic [1:0] aluop[3], m2r[3];
  logic [4:0] exrd[3], wbrd[3];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  int n_asrt = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_control_unit u0 (
    .i_clk(clk), .i_reset(rst), .i_id_opcode(op), .i_id_rd(rd), .i_id_rs1(rs1),
    .i_id_rs2(rs2), .i_flush(fl), .o_stall(st[0]), .o_illegal(il[0]),
    .o_ex_alusrc(alusrc[0]), .o_ex_branch(br[0]), .o_ex_jump(jp[0]), .o_ex_aluop(aluop[0]),
    .o_ex_rd(exrd[0]), .o_mem_read(mr[0]), .o_mem_write(mw[0]), .o_wb_regwrite(rw[0]),
    .o_wb_memtoreg(m2r[0]), .o_wb_rd(wbrd[0]), .o_stall_cnt(sc0), .o_flush_cnt(fc0)
  );

  pipe_control_unit #(.JUMP_EN(1'b0)) u1 (
    .i_clk(clk), .i_reset(rst), .i_id_opcode(op), .i_id_rd(rd), .i_id_rs1(rs1),
    .i_id_rs2(rs2), .i_flush(fl), .o_stall(st[1]), .o_illegal(il[1]),
    .o_ex_alusrc(alusrc[1]), .o_ex_branch(br[1]), .o_ex_jump(jp[1]), .o_ex_aluop(aluop[1]),
    .o_ex_rd(exrd[1]), .o_mem_read(mr[1]), .o_mem_write(mw[1]), .o_wb_regwrite(rw[1]),
    .o_wb_memtoreg(m2r[1]), .o_wb_rd(wbrd[1]), .o_stall_cnt(sc1), .o_flush_cnt(fc1)
  );

  pipe_control_unit #(.CNT_W(2)) u2 (
    .i_clk(clk), .i_reset(rst), .i_id_opcode(op), .i_id_rd(rd), .i_id_rs1(rs1),
    .i_id_rs2(rs2), .i_flush(fl), .o_stall(st[2]), .o_illegal(il[2]),
    .o_ex_alusrc(alusrc[2]), .o_ex_branch(br[2]), .o_ex_jump(jp[2]), .o_ex_aluop(aluop[2]),
    .o_ex_rd(exrd[2]), .o_mem_read(mr[2]), .o_mem_write(mw[2]), .o_wb_regwrite(rw[2]),
    .o_wb_memtoreg(m2r[2]), .o_wb_rd(wbrd[2]), .o_stall_cnt(sc2), .o_flush_cnt(fc2)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       alusrc;
    bit [1:0] aluop;
    bit       branch;
    bit       jump;
    bit       memread;
    bit       memwrite;
    bit       regwrite;
    bit [1:0] memtoreg;
    bit [4:0] rd;
  } m_t;

  // m_pipe[k][n]: instruction that entered ID/EX n edges ago (0 = now in EX).
  m_t m_pipe[3][3];
  int m_scnt[3];
  int m_fcnt[3];
  int m_cmax[3] = '{65535, 65535, 3};

  function automatic m_t m_dec(input bit [6:0] o, input bit [4:0] d, input bit jen);
    m_t m = '0;
    case (o)
      7'b0110011: begin m.regwrite = 1; m.aluop = 2'b10; end
      7'b0000011: begin
        m.memread = 1; m.memtoreg = 2'b01; m.alusrc = 1; m.regwrite = 1; m.aluop = 2'b00;
      end
      7'b0100011: begin m.memwrite = 1; m.alusrc = 1; m.aluop = 2'b00; end
      7'b1100011: begin m.branch = 1; m.aluop = 2'b01; end
      7'b0010011: begin m.alusrc = 1; m.regwrite = 1; m.aluop = 2'b11; end
      7'b1101111: if (jen) begin m.jump = 1; m.regwrite = 1; m.memtoreg = 2'b10; end
      7'b1100111: if (jen) begin
        m.jump = 1; m.alusrc = 1; m.regwrite = 1; m.memtoreg = 2'b10;
      end
      default: ;
    endcase
    if (d == 0) m.regwrite = 0;
    m.rd = d;
    return m;
  endfunction

  function automatic bit m_ill(input bit [6:0] o, input bit jen);
    if (o inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011}) return 0;
    if (jen && (o inside {7'b1101111, 7'b1100111})) return 0;
    return 1;
  endfunction

  function automatic bit m_stall(input int k);
    m_t e = m_pipe[k][0];
    bit src2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    return e.memread && (e.rd != 0) && ((e.rd == rs1) || ((e.rd == rs2) && src2));
  endfunction

  function automatic logic [21:0] expv(input int k);
    m_t e = m_pipe[k][0];
    m_t m = m_pipe[k][1];
    m_t w = m_pipe[k][2];
    return {m_stall(k), m_ill(op, k != 1), e.alusrc, e.aluop, e.branch, e.jump, e.rd,
            m.memread, m.memwrite, w.regwrite, w.memtoreg, w.rd};
  endfunction

  function automatic logic [21:0] actv(input int k);
    return {st[k], il[k], alusrc[k], aluop[k], br[k], jp[k], exrd[k],
            mr[k], mw[k], rw[k], m2r[k], wbrd[k]};
  endfunction

  function automatic int gsc(input int k);
    return (k == 0) ? int'(sc0) : (k == 1) ? int'(sc1) : int'(sc2);
  endfunction

  function automatic int gfc(input int k);
    return (k == 0) ? int'(fc0) : (k == 1) ? int'(fc1) : int'(fc2);
  endfunction

  // Advance one clock edge, updating the model with the inputs of this cycle.
  task automatic cyc();
    bit s[3];
    for (int k = 0; k < 3; k++) s[k] = m_stall(k);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int n = 0; n < 3; n++) m_pipe[k][n] = '0;
        m_scnt[k] = 0;
        m_fcnt[k] = 0;
      end else begin
        m_pipe[k][2] = m_pipe[k][1];
        m_pipe[k][1] = m_pipe[k][0];
        m_pipe[k][0] = (fl || s[k]) ? m_t'('0) : m_dec(op, rd, k != 1);
        if (fl && m_fcnt[k] < m_cmax[k]) m_fcnt[k]++;
        if (s[k] && !fl && m_scnt[k] < m_cmax[k]) m_scnt[k]++;
      end
    end
    #1;
  endtask

  task automatic setid(input bit [6:0] o, input bit [4:0] d, input bit [4:0] a,
                       input bit [4:0] b, input bit f);
    op = o; rd = d; rs1 = a; rs2 = b; fl = f;
    #1;
  endtask

  task automatic nop();
    setid(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] req);
    n_asrt++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          n_asrt += 3;
          if (actv(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL stage_outputs[u%0d] t=%0t: got %h, required %h",
                     k, $time, actv(k), expv(k));
          end
          if (gsc(k) != m_scnt[k]) begin
            n_fail++;
            $display("FAIL stall_cnt[u%0d] t=%0t: got %0d, required %0d",
                     k, $time, gsc(k), m_scnt[k]);
          end
          if (gfc(k) != m_fcnt[k]) begin
            n_fail++;
            $display("FAIL flush_cnt[u%0d] t=%0t: got %0d, required %0d",
                     k, $time, gfc(k), m_fcnt[k]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hold;
    int idx;
    bit [6:0] ops[9];
    ops = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h6F, 7'h67, 7'h7F, 7'h00};
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 3; n++) m_pipe[k][n] = '0;
      m_scnt[k] = 0;
      m_fcnt[k] = 0;
    end

    rst = 1'b1;
    nop();
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    lit("reset_stall", 16'(st[0]), 16'd0);
    lit("reset_wb_regwrite", 16'(rw[0]), 16'd0);
    lit("reset_stall_cnt", sc0, 16'd0);
    lit("reset_flush_cnt", fc0, 16'd0);

    // R-type rd=3 reaches WB exactly three edges later.
    setid(7'b0110011, 5'd3, 5'd1, 5'd2, 1'b0);
    cyc();
    nop();
    cyc();
    lit("r_wb_not_early", 16'(rw[0]), 16'd0);
    cyc();
    lit("r_wb_regwrite", 16'(rw[0]), 16'd1);
    lit("r_wb_memtoreg", 16'(m2r[0]), 16'd0);
    lit("r_wb_rd", 16'(wbrd[0]), 16'd3);

    // Load rd=5 then R-type reading x5: one stall, one bubble.
    setid(7'b0000011, 5'd5, 5'd1, 5'd0, 1'b0);
    cyc();
    setid(7'b0110011, 5'd6, 5'd5, 5'd7, 1'b0);
    lit("loaduse_stall", 16'(st[0]), 16'd1);
    cyc();
    lit("loaduse_stall_one_cycle", 16'(st[0]), 16'd0);
    lit("loaduse_ex_bubble_rd", 16'(exrd[0]), 16'd0);
    cyc();
    nop();
    lit("loaduse_stall_cnt", sc0, 16'd1);
    cyc();
    lit("bubble_in_wb_regwrite", 16'(rw[0]), 16'd0);
    lit("bubble_in_wb_rd", 16'(wbrd[0]), 16'd0);
    cyc();
    lit("r_after_bubble_wb_rd", 16'(wbrd[0]), 16'd6);

    // No hazard through x0, nor on rs2 of an I-type.
    setid(7'b0000011, 5'd0, 5'd1, 5'd0, 1'b0);
    cyc();
    setid(7'b0010011, 5'd7, 5'd0, 5'd0, 1'b0);
    lit("x0_no_stall", 16'(st[0]), 16'd0);
    cyc();
    setid(7'b0000011, 5'd5, 5'd1, 5'd0, 1'b0);
    cyc();
    setid(7'b0010011, 5'd7, 5'd1, 5'd5, 1'b0);
    lit("itype_rs2_no_stall", 16'(st[0]), 16'd0);
    cyc();

    // Flush together with stall.
    setid(7'b0000011, 5'd5, 5'd1, 5'd0, 1'b0);
    cyc();
    setid(7'b0110011, 5'd6, 5'd5, 5'd0, 1'b1);
    lit("flush_stall_both", 16'(st[0]), 16'd1);
    cyc();
    nop();
    lit("flush_ex_ctrls", 16'({alusrc[0], aluop[0], br[0], jp[0]}), 16'd0);
    lit("flush_ex_rd", 16'(exrd[0]), 16'd0);
    lit("flush_cnt_one", fc0, 16'd1);
    lit("flush_stall_cnt_kept", sc0, 16'd1);

    // Illegal opcodes.
    setid(7'b1111111, 5'd2, 5'd0, 5'd0, 1'b0);
    lit("illegal_7f", 16'(il[0]), 16'd1);
    cyc();
    lit("illegal_ex_ctrls", 16'({alusrc[0], aluop[0], br[0], jp[0]}), 16'd0);
    setid(7'b1101111, 5'd1, 5'd0, 5'd0, 1'b0);
    lit("jal_legal_en", 16'(il[0]), 16'd0);
    lit("jal_illegal_noen", 16'(il[1]), 16'd1);
    cyc();
    nop();
    lit("jal_ex_jump_en", 16'(jp[0]), 16'd1);
    lit("jal_ex_jump_noen", 16'(jp[1]), 16'd0);
    cyc();

    // Five stalls: the 2-bit counter saturates.
    repeat (5) begin
      setid(7'b0000011, 5'd5, 5'd1, 5'd0, 1'b0);
      cyc();
      setid(7'b0110011, 5'd6, 5'd5, 5'd0, 1'b0);
      cyc();
      cyc();
      nop();
      cyc();
    end
    lit("sat_stall_cnt_w2", 16'(sc2), 16'd3);
    lit("stall_cnt_w16", sc0, 16'd6);

    // Reset in the middle of traffic.
    setid(7'b0110011, 5'd3, 5'd1, 5'd2, 1'b0);
    cyc();
    setid(7'b0000011, 5'd4, 5'd1, 5'd0, 1'b0);
    cyc();
    rst = 1'b1;
    nop();
    cyc();
    rst = 1'b0;
    #1;
    lit("midreset_ex", 16'({alusrc[0], aluop[0], br[0], jp[0], exrd[0]}), 16'd0);
    lit("midreset_mem", 16'({mr[0], mw[0]}), 16'd0);
    lit("midreset_wb", 16'({rw[0], m2r[0], wbrd[0]}), 16'd0);
    lit("midreset_cnts", 16'({sc2, fc2}), 16'd0);
    lit("midreset_stall", 16'(st[0]), 16'd0);
    repeat (3) begin
      cyc();
      lit("midreset_no_write", 16'(rw[0]), 16'd0);
    end

    // Randomized traffic; ID holds while stalled, as a real front end would.
    for (int i = 0; i < 3000; i++) begin
      hold = m_stall(0) && !fl && !rst;
      cyc();
      if (!hold) begin
        idx = $urandom_range(0, 9);
        op = (idx == 9) ? 7'($urandom) : ops[idx];
        rd = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
    end
    rst = 1'b0;
    nop();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter JUMP_EN, default 1, enables JAL/JALR decode; 0 treats them as illegal.
REQ-002 Parameter REG_ADDR_W, default 5, register-index width.
REQ-003 Parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 id_opcode  in  7  opcode of the instruction currently in ID.
REQ-007 id_rd, id_rs1, id_rs2  in  REG_ADDR_W each  register indices of the ID instruction.
REQ-008 flush  in  1  branch/jump taken, resolved in EX.
REQ-009 stall  out  1  load-use hazard; holds PC and IF/ID and inserts a bubble.
REQ-010 illegal  out  1  ID opcode is not in the decode table.
REQ-011 ex_alusrc, ex_branch, ex_jump  out  1 each  EX-stage controls.
REQ-012 ex_aluop  out  2  EX-stage ALU operation class.
REQ-013 ex_rd  out  REG_ADDR_W  destination index in EX.
REQ-014 mem_read, mem_write  out  1 each  MEM-stage controls.
REQ-015 wb_regwrite  out  1  WB-stage register-file write enable.
REQ-016 wb_memtoreg  out  2  WB source select: 00 ALU, 01 memory, 10 PC+4.
REQ-017 wb_rd  out  REG_ADDR_W  WB destination index.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-019 Decode SHALL be as follows; every control not listed is 0:
- 0110011: regwrite, aluop=10.
- 0000011: memread, memtoreg=01, alusrc, regwrite, aluop=00.
- 0100011: memwrite, alusrc, aluop=00.
- 1100011: branch, aluop=01.
- 0010011: alusrc, regwrite, aluop=11.
- 1101111 (JUMP_EN=1): jump, regwrite, memtoreg=10.
- 1100111 (JUMP_EN=1): jump, alusrc, regwrite, memtoreg=10.
REQ-020 Any other opcode SHALL decode to all-zero controls and SHALL assert illegal combinationally; no X values SHALL appear on any output.
REQ-021 regwrite SHALL be forced to 0 whenever rd equals 0.
REQ-022 Decoded controls SHALL appear on ex_* one cycle after ID, on mem_* after two cycles, and on wb_* after three cycles; rd SHALL travel with them.
REQ-023 stall SHALL be asserted combinationally when all of the following hold:
- the EX stage has mem_read set;
- ex_rd is not 0;
- ex_rd equals id_rs1, or ex_rd equals id_rs2 and the ID opcode is R, store or branch.
REQ-024 While stall is asserted, the ID/EX register SHALL load a bubble (all controls 0, rd 0) and the EX/MEM and MEM/WB stages SHALL advance normally.
REQ-025 While flush is asserted, the ID/EX register SHALL load a bubble on the next edge.
REQ-026 flush SHALL have priority over stall, and stall_cnt SHALL NOT increment in a cycle where flush is asserted.
REQ-027 stall_cnt SHALL increment in each cycle where stall is asserted and flush is not.
REQ-028 flush_cnt SHALL increment in each cycle where flush is asserted.
REQ-029 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.

Reset
REQ-030 On a reset edge, all stage registers, all outputs and both counters SHALL become 0; stall SHALL read 0 in the cycle after reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight controls in the same edge, and no write SHALL issue afterwards.
REQ-032 reset SHALL have priority over flush and stall.

Structure
REQ-033 A shared package pipe_ctrl_pkg SHALL hold:
- opcode constants;
- ALUOp and memtoreg encodings;
- a packed control typedef (alusrc, aluop, branch, jump, memread, memwrite, regwrite, memtoreg).
REQ-034 Combinational decode SHALL live in one sub-module, ctrl_decoder, with pipeline and hazard logic in pipe_control_unit.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Issue 0110011 with rd=3: wb_regwrite=1, wb_memtoreg=00 and wb_rd=3 exactly 3 cycles later.
- Issue a load with rd=5, then 0110011 with rs1=5: stall=1 for 1 cycle, one bubble reaches WB, stall_cnt=1.
- Issue a load with rd=0, then rs1=0: stall=0; a load with rd=5 followed by 0010011 with rs2=5: stall=0.
- Assert flush and stall in the same cycle: ex_* all 0 next cycle, flush_cnt=1, stall_cnt unchanged.
- Opcode 1111111: illegal=1 and all stage controls 0; opcode 1101111 with JUMP_EN=0: illegal=1.
- CNT_W=2 with 5 stalls: stall_cnt=3; reset mid-stream: all outputs 0 on the next cycle.
